period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 16 +
 rtl/period_meter_sync_edge.sv | 45 ++++
 rtl/period_meter.sv | 164 ++++++++++++++++
 tb/tb_period_meter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and default sizing.
package period_meter_pkg;

    // Measurement FSM states; the encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        STALL   = 2'd3
    } pm_state_e;

    // Default counter width and stall timeout (in clk cycles).
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1000;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Two-flop synchronizer plus history flop with registered rise/fall strobes.
// q is the history flop, so q goes high in the same cycle that rise pulses.
// A three-stage "live" shift register blocks edge detection until the
// history flop holds a genuinely sampled value, so an input that is already
// high when reset releases never produces a rise.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic       s1_q;
    logic       s2_q;
    logic       hist_q;
    logic       rise_q;
    logic       fall_q;
    logic [2:0] live_q;

    // Synchronize d, keep one cycle of history and register the edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            live_q <= 3'b000;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            hist_q <= s2_q;
            live_q <= {live_q[1:0], 1'b1};
            rise_q <= s2_q & ~hist_q & live_q[2];
            fall_q <= ~s2_q & hist_q & live_q[2];
        end
    end

    assign q    = hist_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/period_meter.sv
// Period / high-time meter for an asynchronous input signal.
// Counts clk cycles between successive rising edges of sig_in and the number
// of those cycles the signal was high; flags stalls and counter saturation.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stalled,
    output logic             saturated
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

    pm_state_e        state_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             valid_q;
    logic             stalled_q;
    logic             saturated_q;

    logic [CNT_W-1:0] per_next_d;
    logic [CNT_W-1:0] hi_next_d;
    logic             sync_s;
    logic             rise_s;
    logic             fall_unused_s;
    logic             per_hit_max_s;
    logic             hi_hit_max_s;
    logic             timeout_s;

    sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .q    (sync_s),
        .rise (rise_s),
        .fall (fall_unused_s)
    );

    // Saturating increments of both measurement counters.
    always_comb begin
        per_next_d = per_cnt_q;
        hi_next_d  = hi_cnt_q;
        if (per_cnt_q != CNT_MAX) begin
            per_next_d = per_cnt_q + CNT_ONE;
        end else begin
            per_next_d = CNT_MAX;
        end
        if (hi_cnt_q != CNT_MAX) begin
            hi_next_d = hi_cnt_q + CNT_ONE;
        end else begin
            hi_next_d = CNT_MAX;
        end
    end

    // The stall fires on the cycle the incremented count would reach TIMEOUT,
    // so stalled rises exactly TIMEOUT cycles after the last rise pulse.
    assign per_hit_max_s = (per_next_d == CNT_MAX);
    assign hi_hit_max_s  = sync_s && (hi_next_d == CNT_MAX);
    assign timeout_s     = (per_next_d >= TMO);

    // Measurement FSM with counters and registered outputs; enable=0 overrides all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!enable) begin
                state_q   <= IDLE;
                per_cnt_q <= '0;
                hi_cnt_q  <= '0;
                stalled_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q     <= ARM;
                        per_cnt_q   <= '0;
                        hi_cnt_q    <= '0;
                        saturated_q <= 1'b0;
                    end
                    ARM: begin
                        if (rise_s) begin
                            state_q   <= MEASURE;
                            per_cnt_q <= CNT_ONE;
                            hi_cnt_q  <= CNT_ONE;
                        end else begin
                            per_cnt_q <= per_next_d;
                            if (per_hit_max_s) begin
                                saturated_q <= 1'b1;
                            end
                            if (timeout_s) begin
                                state_q   <= STALL;
                                stalled_q <= 1'b1;
                            end
                        end
                    end
                    MEASURE: begin
                        if (rise_s) begin
                            period_q    <= per_cnt_q;
                            high_time_q <= hi_cnt_q;
                            valid_q     <= 1'b1;
                            per_cnt_q   <= CNT_ONE;
                            hi_cnt_q    <= CNT_ONE;
                        end else begin
                            per_cnt_q <= per_next_d;
                            if (sync_s) begin
                                hi_cnt_q <= hi_next_d;
                            end
                            if (per_hit_max_s || hi_hit_max_s) begin
                                saturated_q <= 1'b1;
                            end
                            if (timeout_s) begin
                                state_q   <= STALL;
                                stalled_q <= 1'b1;
                            end
                        end
                    end
                    STALL: begin
                        if (rise_s) begin
                            state_q   <= MEASURE;
                            per_cnt_q <= CNT_ONE;
                            hi_cnt_q  <= CNT_ONE;
                            stalled_q <= 1'b0;
                        end else begin
                            stalled_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        per_cnt_q <= '0;
                        hi_cnt_q  <= '0;
                        stalled_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign stalled   = stalled_q;
    assign saturated = saturated_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: a 16-bit instance (TIMEOUT=64) for the
// measurement, stall, enable and reset sequences, and a 4-bit instance
// (TIMEOUT=15) for saturation and minimum-period behaviour.
module tb_period_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, sig_a, en_b, sig_b;
    logic [15:0] period_a, high_a;
    logic        valid_a, stalled_a, sat_a;
    logic [3:0]  period_b, high_b;
    logic        valid_b, stalled_b, sat_b;

    period_meter #(.CNT_W(16), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .sig_in(sig_a),
        .period(period_a), .high_time(high_a), .valid(valid_a),
        .stalled(stalled_a), .saturated(sat_a)
    );

    period_meter #(.CNT_W(4), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .sig_in(sig_b),
        .period(period_b), .high_time(high_b), .valid(valid_b),
        .stalled(stalled_b), .saturated(sat_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int hi;
    } meas_t;

    typedef struct {
        int n;      // period in clk cycles
        int h;      // high cycles
        int p;      // number of periods
        int cnt;    // expected valid pulses
        int f_per;  // first reported period (boundary)
        int f_hi;
        int l_per;  // steady-state period
        int l_hi;
    } vec_t;

    meas_t log_a[$];
    meas_t log_b[$];
    int    consec_a = 0;
    int    consec_b = 0;
    logic  prev_va  = 1'b0;
    logic  prev_vb  = 1'b0;
    int    tests    = 0;
    int    fails    = 0;
    vec_t  vecs[6];

    // Record every valid pulse and any back-to-back valids.
    always @(negedge clk) begin
        if (valid_a === 1'b1) log_a.push_back('{per: int'(period_a), hi: int'(high_a)});
        if (valid_b === 1'b1) log_b.push_back('{per: int'(period_b), hi: int'(high_b)});
        if (valid_a === 1'b1 && prev_va === 1'b1) consec_a <= consec_a + 1;
        if (valid_b === 1'b1 && prev_vb === 1'b1) consec_b <= consec_b + 1;
        prev_va <= valid_a;
        prev_vb <= valid_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wave_a(input int n, input int h, input int p);
        for (int c = 0; c < p; c++) begin
            for (int j = 0; j < n; j++) begin
                @(negedge clk);
                sig_a = (j < h) ? 1'b1 : 1'b0;
            end
        end
    endtask

    task automatic wave_b(input int n, input int h, input int p);
        for (int c = 0; c < p; c++) begin
            for (int j = 0; j < n; j++) begin
                @(negedge clk);
                sig_b = (j < h) ? 1'b1 : 1'b0;
            end
        end
    endtask

    // Check the single valid expected in log_a after a two-rise sequence.
    task automatic check_one_a(input string name, input int per, input int hi);
        check({name, "_cnt"}, log_a.size(), 1);
        if (log_a.size() > 0) begin
            check({name, "_per"}, log_a[0].per, per);
            check({name, "_hi"}, log_a[0].hi, hi);
        end
        log_a.delete();
    endtask

    initial begin
        vecs[0] = '{10, 5,  6, 5, 10,  5, 10,  5};
        vecs[1] = '{10, 3,  4, 4, 10,  5, 10,  3};
        vecs[2] = '{20, 10, 3, 3, 10,  3, 20, 10};
        vecs[3] = '{7,  1,  4, 4, 20, 10,  7,  1};
        vecs[4] = '{63, 20, 2, 2,  7,  1, 63, 20};
        vecs[5] = '{6,  5,  3, 3, 63, 20,  6,  5};

        rst = 1'b1; en_a = 1'b0; sig_a = 1'b0; en_b = 1'b0; sig_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period", period_a, 0);
        check("rst_high", high_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_stalled", stalled_a, 0);
        check("rst_sat", sat_a, 0);
        check("rst_b_sat", sat_b, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        en_a = 1'b1;

        // Continuous waveform table: duty, asymmetric, period switch, rise+timeout.
        for (int i = 0; i < 6; i++) begin
            int bad;
            wave_a(vecs[i].n, vecs[i].h, vecs[i].p);
            #1;
            check($sformatf("v%0d_cnt", i), log_a.size(), vecs[i].cnt);
            if (log_a.size() > 0) begin
                check($sformatf("v%0d_first_per", i), log_a[0].per, vecs[i].f_per);
                check($sformatf("v%0d_first_hi", i), log_a[0].hi, vecs[i].f_hi);
                check($sformatf("v%0d_last_per", i), log_a[log_a.size()-1].per, vecs[i].l_per);
                check($sformatf("v%0d_last_hi", i), log_a[log_a.size()-1].hi, vecs[i].l_hi);
            end
            bad = 0;
            for (int k = 1; k < log_a.size(); k++) begin
                if (log_a[k].per != vecs[i].l_per || log_a[k].hi != vecs[i].l_hi) bad++;
            end
            check($sformatf("v%0d_steady", i), bad, 0);
            check($sformatf("v%0d_stalled", i), stalled_a, 0);
            log_a.delete();
        end

        // Stall: last rise then low; stalled exactly 64 cycles after the rise pulse.
        @(negedge clk); sig_a = 1'b1;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (j == 66) check("stall_early", stalled_a, 0);
            if (j == 67) check("stall_on_time", stalled_a, 1);
            if (j == 10) log_a.delete();
            sig_a = (j < 5) ? 1'b1 : 1'b0;
        end
        check("stall_no_valid", log_a.size(), 0);

        // Recovery: stalled clears at the first rise, first period discarded.
        @(negedge clk); sig_a = 1'b1;
        for (int j = 1; j <= 19; j++) begin
            @(negedge clk);
            if (j == 3) check("recover_still_stalled", stalled_a, 1);
            if (j == 4) begin
                check("recover_stalled_clr", stalled_a, 0);
                check("recover_no_valid", valid_a, 0);
            end
            if (j == 14) begin
                check("recover_valid", valid_a, 1);
                check("recover_per", period_a, 10);
                check("recover_hi", high_a, 5);
            end
            sig_a = ((j % 10) < 5) ? 1'b1 : 1'b0;
        end
        log_a.delete();

        // Enable drop in the same cycle as a rise: enable wins, outputs hold.
        wave_a(8, 2, 3);
        wave_a(9, 4, 1);
        @(negedge clk); sig_a = 1'b1;
        @(negedge clk); sig_a = 1'b1;
        @(negedge clk); sig_a = 1'b1;
        @(negedge clk); en_a = 1'b0; sig_a = 1'b1;
        for (int j = 4; j <= 23; j++) begin
            @(negedge clk);
            if (j == 4) begin
                check("drop_valid", valid_a, 0);
                check("drop_hold_per", period_a, 8);
                check("drop_hold_hi", high_a, 2);
                check("drop_stalled", stalled_a, 0);
                log_a.delete();
            end
            sig_a = ((j < 5) || (j >= 10 && j < 13)) ? 1'b1 : 1'b0;
        end
        check("drop_idle_per", period_a, 8);
        check("drop_idle_no_valid", log_a.size(), 0);
        en_a = 1'b1;
        wave_a(10, 5, 1);
        #1;
        check("reen_first_rise_no_valid", log_a.size(), 0);
        wave_a(10, 5, 1);
        #1;
        check_one_a("reen", 10, 5);

        // Async reset mid-measurement with sig_in held high through release.
        @(negedge clk); sig_a = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_period", period_a, 0);
        check("arst_high", high_a, 0);
        check("arst_valid", valid_a, 0);
        check("arst_stalled", stalled_a, 0);
        check("arst_sat", sat_a, 0);
        @(negedge clk); rst = 1'b0;
        log_a.delete();
        repeat (10) @(negedge clk);
        check("arst_hold_period", period_a, 0);
        repeat (5) begin
            @(negedge clk); sig_a = 1'b0;
        end
        wave_a(10, 5, 1);
        #1;
        check("arst_no_spurious_rise", log_a.size(), 0);
        wave_a(10, 5, 1);
        #1;
        check_one_a("arst_after", 10, 5);
        check("a_sat_never", sat_a, 0);

        // Saturation on the 4-bit instance: period 20 > TIMEOUT=15.
        @(negedge clk); en_b = 1'b1;
        @(negedge clk); sig_b = 1'b1;
        for (int j = 1; j <= 39; j++) begin
            @(negedge clk);
            if (j == 17) begin
                check("b_stall_early", stalled_b, 0);
                check("b_sat_early", sat_b, 0);
            end
            if (j == 18) begin
                check("b_stall", stalled_b, 1);
                check("b_sat", sat_b, 1);
            end
            if (j == 23) check("b_stall_hold", stalled_b, 1);
            if (j == 24) begin
                check("b_stall_clr", stalled_b, 0);
                check("b_sat_sticky", sat_b, 1);
            end
            if (j == 38) check("b_stall_again", stalled_b, 1);
            sig_b = ((j % 20) < 10) ? 1'b1 : 1'b0;
        end
        check("b_no_valid_p20", log_b.size(), 0);

        // Minimum period of 2 clk cycles.
        wave_b(2, 1, 20);
        repeat (6) begin
            @(negedge clk); sig_b = 1'b0;
        end
        #1;
        check("b_min_cnt", log_b.size(), 19);
        begin
            int bad = 0;
            for (int k = 0; k < log_b.size(); k++) begin
                if (log_b[k].per != 2 || log_b[k].hi != 1) bad++;
            end
            check("b_min_values", bad, 0);
        end
        check("b_min_stalled", stalled_b, 0);
        check("b_min_sat_sticky", sat_b, 1);

        // Enable drop keeps saturated; the IDLE->ARM transition clears it.
        @(negedge clk); en_b = 1'b0;
        @(negedge clk);
        check("b_sat_idle_hold", sat_b, 1);
        en_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b_sat_clr_on_enable", sat_b, 0);
        check("b_stalled_clr", stalled_b, 0);

        check("a_no_consec_valid", consec_a, 0);
        check("b_no_consec_valid", consec_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
